note_sequencer: RTL

Reads the 8-bit step pattern held by the note register and plays it out one step at a time at a fixed tempo. For each active step it emits a one-cycle trigger pulse and a fixed-length gate. The pattern is snapshotted at each bar boundary, so edits made mid-bar take effect only at the next bar. The block sits between the note register and the drum-voice/audio trigger logic.

---
 rtl/seq_pkg.sv | 15 +
 rtl/step_timer.sv | 28 ++
 rtl/note_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the step sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOPPING
    } seq_state_t;

    localparam int NUM_STEPS = 8;
    localparam int STEP_W    = 3;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

endpackage

// File: rtl/step_timer.sv
// Tempo divider: one step_tick every CLKS_PER_STEP cycles while enabled.
module step_timer #(
    parameter int CLKS_PER_STEP = 6250000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic en,
    output logic step_tick
);

    localparam int DIV_W = $clog2(CLKS_PER_STEP);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_STEP - 1);

    logic [DIV_W-1:0] r_div;

    assign step_tick = en && (r_div == DIV_MAX);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (!en || step_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays an 8-step pattern at a fixed tempo; pattern is latched per bar.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int CLKS_PER_STEP = 6250000,
    parameter int GATE_CLKS     = 2500000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NUM_STEPS-1:0] notes,
    output logic [STEP_W-1:0]    step,
    output logic                 trigger,
    output logic                 gate,
    output logic                 bar_start,
    output logic                 playing
);

    localparam int GW = $clog2(GATE_CLKS + 1);
    localparam logic [GW-1:0] GATE_LD = GW'(GATE_CLKS);

    if (CLKS_PER_STEP < 2 || GATE_CLKS < 1 ||
        GATE_CLKS >= CLKS_PER_STEP) begin : g_bad_params
        $error("note_sequencer: illegal CLKS_PER_STEP/GATE_CLKS");
    end

    seq_state_t           r_state;
    seq_state_t           w_state_n;
    logic [STEP_W-1:0]    r_step;
    logic [STEP_W-1:0]    w_step_n;
    logic [STEP_W-1:0]    w_step_inc;
    logic [NUM_STEPS-1:0] r_snap;
    logic [NUM_STEPS-1:0] w_snap_n;
    logic                 r_trig;
    logic                 w_trig_n;
    logic                 r_bar;
    logic                 w_bar_n;
    logic [GW-1:0]        r_gcnt;
    logic [GW-1:0]        w_gcnt_n;
    logic                 w_tick;
    logic                 w_en;
    logic                 w_go;

    assign w_en       = (r_state != S_IDLE);
    assign w_go       = start && !stop;
    assign w_step_inc = r_step + STEP_W'(1);

    step_timer #(
        .CLKS_PER_STEP(CLKS_PER_STEP)
    ) u_timer (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (w_en),
        .step_tick(w_tick)
    );

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_snap  <= '0;
            r_trig  <= 1'b0;
            r_bar   <= 1'b0;
            r_gcnt  <= '0;
        end else begin
            r_state <= w_state_n;
            r_step  <= w_step_n;
            r_snap  <= w_snap_n;
            r_trig  <= w_trig_n;
            r_bar   <= w_bar_n;
            r_gcnt  <= w_gcnt_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_step_n  = r_step;
        w_snap_n  = r_snap;
        w_trig_n  = 1'b0;
        w_bar_n   = 1'b0;
        w_gcnt_n  = (r_gcnt != '0) ? r_gcnt - GW'(1) : '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_n = S_RUN;
                    w_snap_n  = notes;
                    w_step_n  = '0;
                    w_bar_n   = 1'b1;
                    w_trig_n  = notes[0];
                end
            end
            S_RUN, S_STOPPING: begin
                if (stop) begin
                    w_state_n = S_STOPPING;
                end else if (start) begin
                    w_state_n = S_RUN;
                end
                if (w_tick) begin
                    if (r_step != LAST_STEP) begin
                        w_step_n = w_step_inc;
                        w_trig_n = r_snap[w_step_inc];
                    end else if (r_state == S_STOPPING && !w_go) begin
                        // Bar ends silently: no downbeat when stopping.
                        w_state_n = S_IDLE;
                        w_step_n  = '0;
                        w_gcnt_n  = '0;
                    end else begin
                        w_step_n = '0;
                        w_snap_n = notes;
                        w_bar_n  = 1'b1;
                        w_trig_n = notes[0];
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
        if (w_trig_n) begin
            w_gcnt_n = GATE_LD;
        end
    end

    assign step      = r_step;
    assign trigger   = r_trig;
    assign bar_start = r_bar;
    assign gate      = (r_gcnt != '0);
    assign playing   = (r_state != S_IDLE);

endmodule
